// File: rtl/toom_8_evaluation.sv
// Toom-8 operand evaluation: streams A(x) for x = 0,1,-1,2,-2,...,7,inf using a
// Horner loop whose multiply by the small constant x is built from shifts and adds.
module toom_8_evaluation (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1023:0]       a,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [3:0]          out_idx,
   output logic signed [148:0] out_val,
   output logic                out_last,
   output logic                busy
);

   localparam int unsigned LIMB_W = 128;
   localparam int unsigned OP_W   = 1024;
   localparam int unsigned ACC_W  = 149;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned K_W    = 3;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(14);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EVAL,
      OUT
   } state_e;

   state_e                  state_q;
   logic [OP_W-1:0]         a_q;
   logic [IDX_W-1:0]        idx_q;
   logic [K_W-1:0]          k_q;
   logic signed [ACC_W-1:0] acc_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic                    out_last_q;
   logic                    busy_q;

   logic [LIMB_W-1:0]       limb_k_c;
   logic [K_W-1:0]          x_mag_c;
   logic                    x_neg_c;
   logic signed [ACC_W-1:0] prod_c;
   logic signed [ACC_W-1:0] acc_d;

   assign limb_k_c = a_q[{k_q, 7'd0} +: LIMB_W];

   // Point index 2m-1 is x=+m, 2m is x=-m, so |x| = (idx+1)/2 and odd idx is positive.
   always_comb begin
      x_mag_c = K_W'((5'(idx_q) + 5'd1) >> 1);
      x_neg_c = ~idx_q[0];
      prod_c  = '0;
      if (x_mag_c[0]) prod_c = prod_c + acc_q;
      if (x_mag_c[1]) prod_c = prod_c + (acc_q <<< 1);
      if (x_mag_c[2]) prod_c = prod_c + (acc_q <<< 2);
      if (x_neg_c)    prod_c = -prod_c;
      acc_d = prod_c + $signed({{(ACC_W - LIMB_W){1'b0}}, limb_k_c});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         idx_q       <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  idx_q      <= '0;
                  state_q    <= LOAD;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            LOAD: begin
               acc_q <= (idx_q == '0) ? $signed({{(ACC_W - LIMB_W){1'b0}}, a_q[LIMB_W-1:0]})
                                      : $signed({{(ACC_W - LIMB_W){1'b0}}, a_q[OP_W-1 -: LIMB_W]});
               k_q   <= K_W'(6);
               // Points 0 and inf are single limbs and skip the Horner loop.
               if (idx_q == '0 || idx_q == IDX_LAST) begin
                  state_q     <= OUT;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (idx_q == IDX_LAST);
               end else begin
                  state_q <= EVAL;
               end
            end
            EVAL: begin
               acc_q <= acc_d;
               if (k_q == '0) begin
                  state_q     <= OUT;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b0;
               end else begin
                  k_q <= k_q - K_W'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (idx_q == IDX_LAST) begin
                     state_q    <= IDLE;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b0;
                  end else begin
                     idx_q   <= idx_q + IDX_W'(1);
                     state_q <= LOAD;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // in_ready is held low while rst is asserted.
   assign in_ready  = in_ready_q & ~rst;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign out_idx   = idx_q;
   assign out_val   = acc_q;

endmodule

// File: tb/tb_toom_8_evaluation.sv
// Directed bench for toom_8_evaluation: known operands with hand-derived point values,
// handshake timing, output stall, ignored input pulses and mid-operation reset.
module tb_toom_8_evaluation;

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [1023:0]       a;
   logic                out_valid;
   logic                out_ready;
   logic [3:0]          out_idx;
   logic signed [148:0] out_val;
   logic                out_last;
   logic                busy;

   int tests;
   int fails;

   logic signed [148:0] got_val [15];
   int                  got_idx [15];
   int                  got_cyc [15];
   logic                got_last [15];
   int                  n_got;
   int                  ready_cyc;
   int                  stall_changes;
   bit                  timeout;
   logic                accept_ok;
   logic                glitch_rdy;

   logic [1023:0]       op_ones;
   logic [1023:0]       op_max;
   logic [1023:0]       op_x7;
   int                  s_ones [15];
   int                  s_x7 [15];

   toom_8_evaluation dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_val   (out_val),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one operand and records every transferred result with its cycle offset.
   task automatic run_op(input logic [1023:0] op, input int stall_idx, input int glitch_rel,
                         input logic [1023:0] other);
      int                  rel;
      int                  stall_left;
      bit                  stall_seen;
      logic signed [148:0] hold_val;
      logic [3:0]          hold_idx;
      n_got = 0; ready_cyc = -1; timeout = 0; stall_changes = 0; glitch_rdy = 1'b1;
      stall_left = 0; stall_seen = 0; hold_val = '0; hold_idx = '0;
      for (int i = 0; i < 15; i++) begin
         got_val[i] = '0; got_idx[i] = -1; got_cyc[i] = -1; got_last[i] = 1'b0;
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; a = op; out_ready = 1'b1;
      accept_ok = in_ready;
      rel = 0;
      while (ready_cyc < 0) begin
         @(negedge clk);
         rel++;
         in_valid = 1'b0;
         if (rel == glitch_rel) begin
            in_valid = 1'b1; a = other; glitch_rdy = in_ready;
         end
         if (out_valid) begin
            if (int'(out_idx) == stall_idx && !stall_seen) begin
               stall_seen = 1; stall_left = 5; hold_val = out_val; hold_idx = out_idx;
            end
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
               if (out_val !== hold_val || out_idx !== hold_idx) stall_changes++;
            end else begin
               out_ready = 1'b1;
               if (n_got < 15) begin
                  got_val[n_got] = out_val; got_idx[n_got] = int'(out_idx);
                  got_cyc[n_got] = rel; got_last[n_got] = out_last;
                  n_got++;
               end
            end
         end else begin
            if (stall_left > 0) stall_changes++;
            out_ready = 1'b1;
            if (n_got == 15 && in_ready) ready_cyc = rel;
         end
         if (rel > 400) begin
            timeout = 1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0;
      repeat (2) @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold: out_valid=%b busy=%b in_ready=%b out_last=%b, want all 0",
                  out_valid, busy, in_ready, out_last);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: in_ready=%b busy=%b out_valid=%b, want 1 0 0",
                  in_ready, busy, out_valid);
      end
   endtask

   task automatic test_all_ones;
      logic signed [148:0] exp_v;
      int                  exp_c;
      run_op(op_ones, -1, -1, '0);
      tests++;
      if (!accept_ok || timeout || n_got != 15) begin
         fails++;
         $display("FAIL ones_run: accept=%b timeout=%0d results=%0d, want 1 0 15", accept_ok, timeout, n_got);
      end
      for (int i = 0; i < 15; i++) begin
         exp_v = s_ones[i];
         exp_c = (i == 14) ? 121 : 2 + 9 * i;
         tests++;
         if (got_val[i] !== exp_v || got_idx[i] != i || got_cyc[i] != exp_c || got_last[i] !== (i == 14)) begin
            fails++;
            $display("FAIL ones_pt%0d: idx=%0d val=%0d cyc=%0d last=%b, want idx=%0d val=%0d cyc=%0d last=%b",
                     i, got_idx[i], got_val[i], got_cyc[i], got_last[i], i, exp_v, exp_c, (i == 14));
         end
      end
      tests++;
      if (ready_cyc != 122) begin
         fails++;
         $display("FAIL ones_ready: in_ready at cycle %0d, want 122", ready_cyc);
      end
   endtask

   task automatic test_all_max;
      logic signed [148:0] m;
      logic signed [148:0] s;
      logic signed [148:0] exp_v;
      m = {21'd0, {128{1'b1}}};
      run_op(op_max, -1, -1, '0);
      for (int i = 0; i < 15; i++) begin
         s = s_ones[i];
         exp_v = m * s;
         tests++;
         if (got_val[i] !== exp_v || got_idx[i] != i) begin
            fails++;
            $display("FAIL max_pt%0d: idx=%0d val=%0d, want idx=%0d val=%0d", i, got_idx[i], got_val[i], i, exp_v);
         end
      end
   endtask

   task automatic test_x7;
      logic signed [148:0] exp_v;
      run_op(op_x7, -1, -1, '0);
      for (int i = 0; i < 15; i++) begin
         exp_v = s_x7[i];
         tests++;
         if (got_val[i] !== exp_v || got_idx[i] != i) begin
            fails++;
            $display("FAIL x7_pt%0d: idx=%0d val=%0d, want idx=%0d val=%0d", i, got_idx[i], got_val[i], i, exp_v);
         end
      end
   endtask

   task automatic test_stall;
      run_op(op_ones, 3, -1, '0);
      tests++;
      if (stall_changes != 0) begin
         fails++;
         $display("FAIL stall_hold: %0d changes while stalled, want 0", stall_changes);
      end
      tests++;
      if (got_idx[3] != 3 || got_val[3] !== 149'sd255 || got_cyc[3] != 34) begin
         fails++;
         $display("FAIL stall_pt3: idx=%0d val=%0d cyc=%0d, want 3 255 34", got_idx[3], got_val[3], got_cyc[3]);
      end
      tests++;
      if (got_idx[4] != 4 || got_val[4] !== -149'sd85 || got_cyc[4] != 43) begin
         fails++;
         $display("FAIL stall_pt4: idx=%0d val=%0d cyc=%0d, want 4 -85 43", got_idx[4], got_val[4], got_cyc[4]);
      end
      tests++;
      if (n_got != 15 || ready_cyc != 127) begin
         fails++;
         $display("FAIL stall_end: results=%0d ready_cyc=%0d, want 15 127", n_got, ready_cyc);
      end
   endtask

   task automatic test_back_to_back;
      logic signed [148:0] exp_v;
      run_op(op_ones, -1, 15, op_x7);
      tests++;
      if (glitch_rdy !== 1'b0) begin
         fails++;
         $display("FAIL b2b_busy_ready: in_ready=%b during EVAL, want 0", glitch_rdy);
      end
      for (int i = 0; i < 15; i++) begin
         exp_v = s_ones[i];
         tests++;
         if (got_val[i] !== exp_v || got_idx[i] != i) begin
            fails++;
            $display("FAIL b2b_first_pt%0d: idx=%0d val=%0d, want idx=%0d val=%0d", i, got_idx[i], got_val[i], i, exp_v);
         end
      end
      run_op(op_x7, -1, -1, '0);
      tests++;
      if (!accept_ok || n_got != 15) begin
         fails++;
         $display("FAIL b2b_second_accept: accept=%b results=%0d, want 1 15", accept_ok, n_got);
      end
      for (int i = 0; i < 15; i++) begin
         exp_v = s_x7[i];
         tests++;
         if (got_val[i] !== exp_v || got_idx[i] != i) begin
            fails++;
            $display("FAIL b2b_second_pt%0d: idx=%0d val=%0d, want idx=%0d val=%0d", i, got_idx[i], got_val[i], i, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid;
      int                  spurious;
      logic signed [148:0] exp_v;
      @(negedge clk);
      in_valid = 1'b1; a = op_ones; out_ready = 1'b1;
      for (int r = 1; r <= 42; r++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      tests++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || out_idx !== 4'd5) begin
         fails++;
         $display("FAIL rstmid_pre: busy=%b out_valid=%b idx=%0d, want 1 0 5", busy, out_valid, out_idx);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_after: out_valid=%b busy=%b, want 0 0", out_valid, busy);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_ready: in_ready=%b, want 1", in_ready);
      end
      spurious = 0;
      repeat (130) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b0) spurious++;
      end
      tests++;
      if (spurious != 0) begin
         fails++;
         $display("FAIL rstmid_quiet: %0d cycles with activity after abort, want 0", spurious);
      end
      run_op(op_ones, -1, -1, '0);
      for (int i = 0; i < 15; i++) begin
         exp_v = s_ones[i];
         tests++;
         if (got_val[i] !== exp_v || got_idx[i] != i || got_cyc[i] != ((i == 14) ? 121 : 2 + 9 * i)) begin
            fails++;
            $display("FAIL rstmid_pt%0d: idx=%0d val=%0d cyc=%0d, want idx=%0d val=%0d", i, got_idx[i], got_val[i],
                     got_cyc[i], i, exp_v);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0;
      op_ones = '0; op_max = '1; op_x7 = '0;
      for (int i = 0; i < 8; i++) op_ones[128*i +: 128] = 128'd1;
      op_x7[1023:896] = 128'd1;
      s_ones = '{1, 8, 0, 255, -85, 3280, -1640, 21845, -13107, 97656, -65104, 335923, -239945, 960800, 1};
      s_x7   = '{0, 1, -1, 128, -128, 2187, -2187, 16384, -16384, 78125, -78125, 279936, -279936, 823543, 1};
      test_reset;
      test_all_ones;
      test_all_max;
      test_x7;
      test_stall;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
